// File: rtl/alu181_nibble_seq.sv
// alu181_nibble_seq
// Runs a wide (4*NIBBLES bit) operation through a single 4-bit 74181-style
// ALU, one nibble per cycle, rippling the ALU carry-out into the next slice.
//
// Ports:
//   clk, rst           clock (rising edge), synchronous active-high reset
//   start              begin an operation (ignored while busy)
//   a, b, s, m, cin_n  operands, function select, mode, active-low carry-in
//   busy               high while slices are processed
//   done               one-cycle pulse; f / cout_n / eql valid from here on
//   f, cout_n, eql     result word, final active-low carry, AND of A=B
//   alu_a/b/s/m/notc   drive to the external ALU
//   alu_f/cout/eql     combinational return from the external ALU
//
// Build option: define ALU181_SEQ_EQL_EN to accumulate the per-slice A=B
// outputs into eql; when undefined, eql is tied low and alu_eql is ignored.

module alu181_nibble_seq #(
  parameter int NIBBLES = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [4*NIBBLES-1:0] a,
  input  logic [4*NIBBLES-1:0] b,
  input  logic [3:0]           s,
  input  logic                 m,
  input  logic                 cin_n,
  output logic                 busy,
  output logic                 done,
  output logic [4*NIBBLES-1:0] f,
  output logic                 cout_n,
  output logic                 eql,
  output logic [3:0]           alu_a,
  output logic [3:0]           alu_b,
  output logic [3:0]           alu_s,
  output logic                 alu_m,
  output logic                 alu_notc,
  input  logic [3:0]           alu_f,
  input  logic                 alu_cout,
  input  logic                 alu_eql
);

  localparam int IW = $clog2(NIBBLES);
  localparam logic [IW-1:0] LAST = IW'(NIBBLES - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                    state;
  logic [IW-1:0]             idx;
  logic [NIBBLES-1:0][3:0]   a_r, b_r, f_acc, f_next;
  logic [3:0]                s_r;
  logic                      m_r;
  logic                      carry;   // active-low, same polarity as alu_notc

  wire run = (state == RUN);

  // ALU pins are parked (operands 0, no carry) outside RUN.
  assign alu_a    = run ? a_r[idx] : 4'h0;
  assign alu_b    = run ? b_r[idx] : 4'h0;
  assign alu_s    = run ? s_r      : 4'h0;
  assign alu_m    = run ? m_r      : 1'b0;
  assign alu_notc = run ? carry    : 1'b1;

  // Partial word with the current slice merged in; becomes f on the last slice.
  always_comb begin
    f_next      = f_acc;
    f_next[idx] = alu_f;
  end

`ifdef ALU181_SEQ_EQL_EN
  logic eql_acc;
`else
  logic unused_alu_eql;
  assign unused_alu_eql = alu_eql;
  assign eql            = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      busy   <= 1'b0;
      done   <= 1'b0;
      f      <= '0;
      cout_n <= 1'b1;
      idx    <= '0;
      a_r    <= '0;
      b_r    <= '0;
      s_r    <= '0;
      m_r    <= 1'b0;
      carry  <= 1'b1;
      f_acc  <= '0;
`ifdef ALU181_SEQ_EQL_EN
      eql     <= 1'b0;
      eql_acc <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (start) begin
            a_r   <= a;
            b_r   <= b;
            s_r   <= s;
            m_r   <= m;
            carry <= cin_n;
            idx   <= '0;
            f_acc <= '0;
            busy  <= 1'b1;
            state <= RUN;
`ifdef ALU181_SEQ_EQL_EN
            eql_acc <= 1'b1;
`endif
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          f_acc <= f_next;
          carry <= alu_cout;   // Cn+4 -> Cn, no inversion
          idx   <= idx + IW'(1);
`ifdef ALU181_SEQ_EQL_EN
          eql_acc <= eql_acc & alu_eql;
`endif
          if (idx == LAST) begin
            state  <= DONE;
            busy   <= 1'b0;
            done   <= 1'b1;
            f      <= f_next;
            cout_n <= alu_cout;
`ifdef ALU181_SEQ_EQL_EN
            eql    <= eql_acc & alu_eql;
`endif
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu181_nibble_seq.sv
module tb_alu181_nibble_seq;
  localparam int N = 4;
  localparam int W = 4 * N;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] a = '0, b = '0;
  logic [3:0]   s = '0;
  logic         m = 1'b0, cin_n = 1'b1;
  logic         busy, done, cout_n, eql;
  logic [W-1:0] f;
  logic [3:0]   alu_a, alu_b, alu_s, alu_f;
  logic         alu_m, alu_notc, alu_cout, alu_eql;

  int n_checks = 0;
  int n_fail   = 0;
  logic notc_log [8];

`ifdef ALU181_SEQ_EQL_EN
  localparam bit EQL_ON = 1'b1;
`else
  localparam bit EQL_ON = 1'b0;
`endif

  always #5 clk = ~clk;

  alu181_nibble_seq #(.NIBBLES(N)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .s(s), .m(m), .cin_n(cin_n),
    .busy(busy), .done(done), .f(f), .cout_n(cout_n), .eql(eql),
    .alu_a(alu_a), .alu_b(alu_b), .alu_s(alu_s), .alu_m(alu_m), .alu_notc(alu_notc),
    .alu_f(alu_f), .alu_cout(alu_cout), .alu_eql(alu_eql)
  );

  // 74181 logic-mode functions (active-high data), any width up to 32.
  function automatic logic [31:0] logic_fn(input logic [3:0] fs, input logic [31:0] p, q);
    case (fs)
      4'h0: return ~p;        4'h1: return ~(p | q);
      4'h2: return ~p & q;    4'h3: return 32'h0;
      4'h4: return ~(p & q);  4'h5: return ~q;
      4'h6: return p ^ q;     4'h7: return p & ~q;
      4'h8: return ~p | q;    4'h9: return ~(p ^ q);
      4'hA: return q;         4'hB: return p & q;
      4'hC: return 32'hFFFF_FFFF; 4'hD: return p | ~q;
      4'hE: return p | q;     default: return p;
    endcase
  endfunction

  // Stand-in 4-bit ALU: arithmetic is X plus Y plus carry, where X/Y are the
  // datasheet's select-gated terms. A=B is modelled as operand equality.
  logic [3:0] ax, ay;
  logic [4:0] asum;
  logic [31:0] alog;
  always_comb begin
    ax       = alu_a | ({4{alu_s[0]}} & alu_b) | ({4{alu_s[1]}} & ~alu_b);
    ay       = ({4{alu_s[3]}} & alu_a & alu_b) | ({4{alu_s[2]}} & alu_a & ~alu_b);
    asum     = {1'b0, ax} + {1'b0, ay} + {4'b0, ~alu_notc};
    alog     = logic_fn(alu_s, {28'b0, alu_a}, {28'b0, alu_b});
    alu_f    = alu_m ? alog[3:0] : asum[3:0];
    alu_cout = ~asum[4];
    alu_eql  = (alu_a == alu_b);
  end

  // Word-level reference: {eql, cout_n, f} for the whole operation at once.
  function automatic logic [W+1:0] ref_op(input logic [W-1:0] ra, rb, input logic [3:0] rs,
                                          input logic rm, rc);
    logic [W-1:0] x, y, lf;
    logic [W:0]   sum;
    logic [31:0]  t;
    x   = ra | ({W{rs[0]}} & rb) | ({W{rs[1]}} & ~rb);
    y   = ({W{rs[3]}} & ra & rb) | ({W{rs[2]}} & ra & ~rb);
    sum = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, ~rc};
    t   = logic_fn(rs, 32'(ra), 32'(rb));
    lf  = t[W-1:0];
    return {EQL_ON & (ra == rb), ~sum[W], rm ? lf : sum[W-1:0]};
  endfunction

  // Launch one operation and wait (bounded) for done; logs alu_notc per slice.
  task automatic run_op(input logic [W-1:0] ta, tb2, input logic [3:0] ts,
                        input logic tm, tc, output int lat, output int bcnt);
    a = ta; b = tb2; s = ts; m = tm; cin_n = tc; start = 1'b1;
    lat = 0; bcnt = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      start = 1'b0;
      lat++;
      if (busy) begin
        if (bcnt < 8) notc_log[bcnt] = alu_notc;
        bcnt++;
      end
      if (done) break;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if ({busy, done, cout_n, eql} !== 4'b0010) begin
      n_fail++; $display("FAIL reset_flags: got busy/done/cout_n/eql=%b want 0010", {busy, done, cout_n, eql});
    end
    n_checks++;
    if (f !== '0) begin n_fail++; $display("FAIL reset_f: got %h want 0", f); end
    n_checks++;
    if ({alu_a, alu_b, alu_s, alu_m, alu_notc} !== 14'b1) begin
      n_fail++; $display("FAIL reset_alu_pins: got %b want 00..01", {alu_a, alu_b, alu_s, alu_m, alu_notc});
    end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_add();
    int lat, bc;
    run_op(16'h1234, 16'h0FCD, 4'b1001, 1'b0, 1'b1, lat, bc);
    n_checks++;
    if (lat !== N + 1) begin n_fail++; $display("FAIL add_latency: got %0d want %0d", lat, N + 1); end
    n_checks++;
    if (bc !== N) begin n_fail++; $display("FAIL add_busy_cycles: got %0d want %0d", bc, N); end
    n_checks++;
    if ({f, cout_n} !== {16'h2201, 1'b1}) begin
      n_fail++; $display("FAIL add_result: got f=%h cout_n=%b want 2201 1", f, cout_n);
    end
    // Result holds through idle cycles.
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if ({f, busy, done} !== {16'h2201, 2'b00}) begin
      n_fail++; $display("FAIL add_hold: got f=%h busy=%b done=%b want 2201 0 0", f, busy, done);
    end
  endtask

  task automatic test_add_overflow();
    int lat, bc;
    run_op(16'hFFFF, 16'h0001, 4'b1001, 1'b0, 1'b1, lat, bc);
    n_checks++;
    if ({f, cout_n} !== {16'h0000, 1'b0}) begin
      n_fail++; $display("FAIL ovf_result: got f=%h cout_n=%b want 0000 0", f, cout_n);
    end
    n_checks++;
    if ({notc_log[0], notc_log[1], notc_log[2], notc_log[3]} !== 4'b1000 || bc !== N) begin
      n_fail++; $display("FAIL ovf_slice_carry: got notc=%b%b%b%b slices=%0d want 1000 4",
                         notc_log[0], notc_log[1], notc_log[2], notc_log[3], bc);
    end
  endtask

  task automatic test_sub();
    int lat, bc;
    run_op(16'h5A5A, 16'h5A5A, 4'b0110, 1'b0, 1'b0, lat, bc);
    n_checks++;
    if ({f, cout_n, eql} !== {16'h0000, 1'b0, EQL_ON}) begin
      n_fail++; $display("FAIL sub_equal: got f=%h cout_n=%b eql=%b want 0000 0 %b", f, cout_n, eql, EQL_ON);
    end
    run_op(16'h5A5A, 16'h5A5B, 4'b0110, 1'b0, 1'b0, lat, bc);
    n_checks++;
    if ({f, cout_n, eql} !== {16'hFFFF, 1'b1, 1'b0}) begin
      n_fail++; $display("FAIL sub_unequal: got f=%h cout_n=%b eql=%b want ffff 1 0", f, cout_n, eql);
    end
  endtask

  task automatic test_start_while_busy();
    int dones = 0;
    a = 16'hF0F0; b = 16'hFF00; s = 4'b0110; m = 1'b1; cin_n = 1'b1; start = 1'b1;
    @(posedge clk); #1;              // accepted; RUN cycle 1
    start = 1'b0;
    @(posedge clk); #1;              // RUN cycle 2
    start = 1'b1; a = 16'h1111; b = 16'h2222; m = 1'b0; s = 4'b1001;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < 12; i++) begin
      if (done) dones++;
      @(posedge clk); #1;
    end
    n_checks++;
    if (dones !== 1) begin n_fail++; $display("FAIL busy_start_dones: got %0d want 1", dones); end
    n_checks++;
    if (f !== 16'h0FF0) begin n_fail++; $display("FAIL busy_start_f: got %h want 0ff0", f); end
  endtask

  task automatic test_back_to_back();
    logic [W+1:0] expq[$];
    logic [W+1:0] exp_v;
    int t_last = -1, dones = 0, bad_gap = 0;
    a = $urandom; b = $urandom; s = 4'($urandom); m = 1'($urandom); cin_n = 1'($urandom);
    expq.push_back(ref_op(a, b, s, m, cin_n));
    start = 1'b1;
    for (int t = 0; t < 30; t++) begin
      @(posedge clk); #1;
      if (done) begin
        dones++;
        if (t_last >= 0 && t - t_last != N + 1) bad_gap++;
        t_last = t;
        n_checks++;
        if (expq.size() == 0) begin
          n_fail++; $display("FAIL b2b_extra_done: got done at cycle %0d want none", t);
        end else begin
          exp_v = expq.pop_front();
          if ({eql, cout_n, f} !== exp_v) begin
            n_fail++; $display("FAIL b2b_result: got %h want %h", {eql, cout_n, f}, exp_v);
          end
        end
        if (dones < 4) begin
          a = $urandom; b = $urandom; s = 4'($urandom); m = 1'($urandom); cin_n = 1'($urandom);
          expq.push_back(ref_op(a, b, s, m, cin_n));
        end else begin
          start = 1'b0;
        end
      end
    end
    start = 1'b0;
    n_checks++;
    if (dones !== 4 || bad_gap !== 0) begin
      n_fail++; $display("FAIL b2b_cadence: got dones=%0d bad_gaps=%0d want 4 0", dones, bad_gap);
    end
  endtask

  task automatic test_reset_mid_op();
    int lat, bc, dones = 0;
    run_op(16'h1234, 16'h0FCD, 4'b1001, 1'b0, 1'b1, lat, bc);
    a = 16'h7777; b = 16'h1111; s = 4'b1001; m = 1'b0; cin_n = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;              // RUN cycle 2
    rst = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if ({busy, done, f, cout_n, alu_notc} !== {2'b00, 16'h0000, 2'b11}) begin
      n_fail++; $display("FAIL midrst_state: got busy=%b done=%b f=%h cout_n=%b notc=%b want 0 0 0000 1 1",
                         busy, done, f, cout_n, alu_notc);
    end
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (done || busy) dones++;
    end
    n_checks++;
    if (dones !== 0) begin n_fail++; $display("FAIL midrst_no_done: got %0d active cycles want 0", dones); end
  endtask

  task automatic test_random();
    int lat, bc;
    logic [W-1:0] ra, rb;
    logic [3:0]   rs;
    logic         rm, rc;
    logic [W+1:0] exp_v;
    for (int i = 0; i < 40; i++) begin
      ra = $urandom; rs = 4'($urandom); rm = 1'($urandom); rc = 1'($urandom);
      rb = ($urandom_range(0, 3) == 0) ? ra : W'($urandom);
      exp_v = ref_op(ra, rb, rs, rm, rc);
      run_op(ra, rb, rs, rm, rc, lat, bc);
      n_checks++;
      if ({eql, cout_n, f} !== exp_v || lat !== N + 1) begin
        n_fail++; $display("FAIL random_%0d: a=%h b=%h s=%h m=%b cin_n=%b got %h lat=%0d want %h lat=%0d",
                           i, ra, rb, rs, rm, rc, {eql, cout_n, f}, lat, exp_v, N + 1);
      end
      if ($urandom_range(0, 1) == 1) begin
        @(posedge clk); #1;
      end
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_add_overflow();
    test_sub();
    test_start_while_busy();
    test_back_to_back();
    test_reset_mid_op();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
